param_pc_trace_buffer: RTL and testbench
========================================

// Module: param_pc_trace_buffer
//
// PURPOSE
//   Retirement-side observer for the PC register. It ticks on the same gated clock
//   as the PC register, so every non-reset edge corresponds to one retired instruction
//   (last uop) updating PC.
//   - Counts retired instructions and control-flow redirects.
//   - Records {source PC, target PC} for every redirect in a circular trace buffer.
//   - Flags misaligned PC targets.
//   - Exposes a combinational read port for debug.
//
// PARAMETERS
//   DEPTH     8    trace entries; power of 2, >= 2
//   IDX_BITS  3    log2(DEPTH)
//   CNT_W     32   width of instret_cnt and redirect_cnt
//
// PORTS
//   pc_reg_clk_gated  in   1         clock; pulses only on reset or last-uop cycles
//   reset             in   1         reset, synchronous, active-high
//   pc                in   32        current PC (value before this edge)
//   pc_next           in   32        PC value being written at this edge
//   trace_freeze      in   1         1: do not record redirects into the buffer
//   trace_clr         in   1         1: clear buffer state at this edge
//   rd_idx            in   IDX_BITS  read index; 0 = most recent entry
//   rd_valid          out  1         rd_idx < trace_count
//   rd_src_pc         out  32        source PC of the selected entry; 0 if !rd_valid
//   rd_tgt_pc         out  32        target PC of the selected entry; 0 if !rd_valid
//   trace_count       out  IDX_BITS+1  valid entries, 0..DEPTH
//   trace_overflow    out  1         sticky: an unread-oldest entry was overwritten
//   instret_cnt       out  CNT_W     retired-instruction count
//   redirect_cnt      out  CNT_W     redirect count
//   misalign_flag     out  1         sticky: a pc_next had [1:0] != 0
//   misalign_addr     out  32        first misaligned pc_next since last clear
//
// BEHAVIOUR
//   - All state updates occur on posedge pc_reg_clk_gated. There are no other clocks.
//   - Reset edge (reset=1): wr_ptr, trace_count, trace_overflow, instret_cnt,
//     redirect_cnt, misalign_flag and misalign_addr all become 0.
//     The entry RAM is not cleared. Reset overrides every other input.
//   - Retire edge (reset=0):
//     - instret_cnt += 1, modulo 2^CNT_W (wraps to 0).
//     - redirect = (pc_next != pc + 32'd4), using a 32-bit modulo add.
//       Example: pc=FFFFFFFC, pc_next=0 is NOT a redirect.
//     - If redirect: redirect_cnt += 1 (modulo 2^CNT_W). This happens regardless
//       of trace_freeze and trace_clr.
//     - If redirect && !trace_freeze && !trace_clr:
//       - entry[wr_ptr] <= {pc, pc_next}; wr_ptr <= wr_ptr + 1 (mod DEPTH).
//       - If trace_count < DEPTH: trace_count += 1.
//       - Else: trace_count holds at DEPTH, the oldest entry is overwritten,
//         and trace_overflow <= 1.
//     - If pc_next[1:0] != 0 && !trace_clr:
//       - misalign_flag <= 1.
//       - misalign_addr <= pc_next only if misalign_flag was 0 (first one wins).
//     - If trace_clr: wr_ptr, trace_count, trace_overflow, misalign_flag and
//       misalign_addr become 0. The redirect at the same edge is not recorded.
//       instret_cnt and redirect_cnt still update.
//   - Read port is purely combinational, with zero latency:
//     - selected slot = (wr_ptr - 1 - rd_idx) mod DEPTH.
//     - rd_valid = (rd_idx < trace_count).
//     - rd_src_pc / rd_tgt_pc are forced to 0 when !rd_valid.
//     - The read port reflects post-edge state immediately after each edge.
//   - A mid-trace reset discards all entries logically (count=0). Stale RAM
//     contents are never visible because of the rd_valid masking.
//   - Only the state at the sampled edge matters; inputs are don't-care between
//     edges.
//
// TESTING
//   1. Reset edge, then 3 retires 0x80000->0x80004->0x80008->0x8000C:
//      -> instret_cnt=3, redirect_cnt=0, trace_count=0, rd_valid=0.
//   2. pc=0x80010, pc_next=0x80100:
//      -> trace_count=1; rd_idx=0 gives src 0x80010, tgt 0x80100;
//         rd_idx=1 gives rd_valid=0, outputs 0.
//   3. 9 distinct redirects with DEPTH=8:
//      -> trace_count=8, trace_overflow=1; rd_idx=7 returns the 2nd redirect;
//         rd_idx=0 returns the 9th.
//   4. pc_next=0x80102, later pc_next=0x80206:
//      -> misalign_flag=1, misalign_addr stays 0x80102;
//         trace_clr edge -> flag=0, addr=0.
//   5. trace_freeze=1 with a redirect:
//      -> trace_count unchanged, redirect_cnt+1.
//      trace_clr=1 with a redirect at count=4:
//      -> count=0, instret_cnt+1, redirect_cnt+1.
//   6. Reset edge with count=5 and instret=20:
//      -> all outputs 0.
//      Then retire pc=FFFFFFFC, pc_next=0 -> no redirect recorded, instret=1.

Source files
------------

// File: rtl/param_pc_trace_buffer.sv
// Retirement-side PC observer.
// Counts retired instructions and control-flow redirects, records {source, target}
// PC pairs for redirects in a circular trace buffer, flags misaligned PC targets,
// and exposes a zero-latency combinational debug read port (index 0 = newest).
module param_pc_trace_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned IDX_BITS = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                pc_reg_clk_gated,
    input  logic                reset,
    input  logic [31:0]         pc,
    input  logic [31:0]         pc_next,
    input  logic                trace_freeze,
    input  logic                trace_clr,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [31:0]         rd_src_pc,
    output logic [31:0]         rd_tgt_pc,
    output logic [IDX_BITS:0]   trace_count,
    output logic                trace_overflow,
    output logic [CNT_W-1:0]    instret_cnt,
    output logic [CNT_W-1:0]    redirect_cnt,
    output logic                misalign_flag,
    output logic [31:0]         misalign_addr
);

    localparam logic [IDX_BITS:0] FULL_COUNT = (IDX_BITS + 1)'(DEPTH);

    // Entry storage; deliberately not reset, stale data is masked by rd_valid
    logic [31:0]         src_mem [DEPTH];
    logic [31:0]         tgt_mem [DEPTH];

    logic [IDX_BITS-1:0] wr_ptr;
    logic [IDX_BITS-1:0] rd_slot;

    logic                redirect;
    logic                record;
    logic                misaligned;
    logic                buf_full;

    // Classify the retiring instruction at this edge
    always_comb begin
        redirect   = (pc_next != (pc + 32'd4));
        record     = redirect && !trace_freeze && !trace_clr;
        misaligned = (pc_next[1:0] != 2'b00);
        buf_full   = (trace_count == FULL_COUNT);
    end

    // Write the redirect pair into the slot at the write pointer
    always_ff @(posedge pc_reg_clk_gated) begin
        if (!reset && record) begin
            src_mem[wr_ptr] <= pc;
            tgt_mem[wr_ptr] <= pc_next;
        end
    end

    // Retired-instruction and redirect counters; trace_freeze/trace_clr do not affect them
    always_ff @(posedge pc_reg_clk_gated) begin
        if (reset) begin
            instret_cnt  <= '0;
            redirect_cnt <= '0;
        end else begin
            instret_cnt <= instret_cnt + CNT_W'(1);
            if (redirect) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end

    // Circular buffer bookkeeping: pointer, occupancy and sticky overflow
    always_ff @(posedge pc_reg_clk_gated) begin
        if (reset || trace_clr) begin
            wr_ptr         <= '0;
            trace_count    <= '0;
            trace_overflow <= 1'b0;
        end else if (record) begin
            wr_ptr <= wr_ptr + IDX_BITS'(1);
            if (buf_full) begin
                trace_overflow <= 1'b1;
            end else begin
                trace_count <= trace_count + (IDX_BITS + 1)'(1);
            end
        end
    end

    // Sticky misalignment flag; the address of the first offender is kept
    always_ff @(posedge pc_reg_clk_gated) begin
        if (reset || trace_clr) begin
            misalign_flag <= 1'b0;
            misalign_addr <= '0;
        end else if (misaligned) begin
            misalign_flag <= 1'b1;
            if (!misalign_flag) begin
                misalign_addr <= pc_next;
            end
        end
    end

    // Newest-first read: slot arithmetic wraps naturally at the pointer width
    always_comb begin
        rd_slot   = wr_ptr - IDX_BITS'(1) - rd_idx;
        rd_valid  = ({1'b0, rd_idx} < trace_count);
        rd_src_pc = '0;
        rd_tgt_pc = '0;
        if (rd_valid) begin
            rd_src_pc = src_mem[rd_slot];
            rd_tgt_pc = tgt_mem[rd_slot];
        end
    end

endmodule

// File: tb/tb_param_pc_trace_buffer.sv
// Self-checking bench for param_pc_trace_buffer.
// Each retire edge pushes the modelled post-edge state into a scoreboard queue,
// which is popped and compared right after the edge; scenario tasks add their
// own read-port and spot-value checks.
module tb_param_pc_trace_buffer;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned IDX_BITS = 3;
    localparam int unsigned CNT_W    = 32;

    logic                pc_reg_clk_gated;
    logic                reset;
    logic [31:0]         pc;
    logic [31:0]         pc_next;
    logic                trace_freeze;
    logic                trace_clr;
    logic [IDX_BITS-1:0] rd_idx;
    logic                rd_valid;
    logic [31:0]         rd_src_pc;
    logic [31:0]         rd_tgt_pc;
    logic [IDX_BITS:0]   trace_count;
    logic                trace_overflow;
    logic [CNT_W-1:0]    instret_cnt;
    logic [CNT_W-1:0]    redirect_cnt;
    logic                misalign_flag;
    logic [31:0]         misalign_addr;

    param_pc_trace_buffer #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS),
        .CNT_W    (CNT_W)
    ) dut (
        .pc_reg_clk_gated (pc_reg_clk_gated),
        .reset            (reset),
        .pc               (pc),
        .pc_next          (pc_next),
        .trace_freeze     (trace_freeze),
        .trace_clr        (trace_clr),
        .rd_idx           (rd_idx),
        .rd_valid         (rd_valid),
        .rd_src_pc        (rd_src_pc),
        .rd_tgt_pc        (rd_tgt_pc),
        .trace_count      (trace_count),
        .trace_overflow   (trace_overflow),
        .instret_cnt      (instret_cnt),
        .redirect_cnt     (redirect_cnt),
        .misalign_flag    (misalign_flag),
        .misalign_addr    (misalign_addr)
    );

    typedef struct {
        string       tag;
        logic [31:0] instret;
        logic [31:0] redir;
        logic [3:0]  count;
        logic        ovf;
        logic        flag;
        logic [31:0] addr;
    } snap_t;

    snap_t       sb[$];
    logic [63:0] hist[$];   // newest first: {src, tgt}

    logic [31:0] m_instret;
    logic [31:0] m_redir;
    logic        m_ovf;
    logic        m_flag;
    logic [31:0] m_addr;

    int checks;
    int errors;

    // One gated clock pulse per retire: drive, model, push, pulse, pop and compare
    task automatic do_retire(input logic rst, input logic [31:0] p, input logic [31:0] pn,
                             input logic frz, input logic clr, input string tag);
        snap_t e;
        logic  redir;
        reset        = rst;
        pc           = p;
        pc_next      = pn;
        trace_freeze = frz;
        trace_clr    = clr;
        if (rst) begin
            m_instret = 0; m_redir = 0; m_ovf = 0; m_flag = 0; m_addr = 0;
            hist.delete();
        end else begin
            m_instret = m_instret + 32'd1;
            redir = (pn != p + 32'd4);
            if (redir) m_redir = m_redir + 32'd1;
            if (redir && !frz && !clr) begin
                hist.push_front({p, pn});
                if (hist.size() > DEPTH) begin
                    void'(hist.pop_back());
                    m_ovf = 1'b1;
                end
            end
            if (pn[1:0] != 2'b00 && !clr) begin
                if (!m_flag) m_addr = pn;
                m_flag = 1'b1;
            end
            if (clr) begin
                hist.delete();
                m_ovf = 0; m_flag = 0; m_addr = 0;
            end
        end
        e.tag = tag; e.instret = m_instret; e.redir = m_redir; e.count = 4'(hist.size());
        e.ovf = m_ovf; e.flag = m_flag; e.addr = m_addr;
        sb.push_back(e);

        #2 pc_reg_clk_gated = 1'b1;
        #1;
        e = sb.pop_front();
        checks++;
        if (instret_cnt !== e.instret) begin
            errors++; $display("FAIL %s instret_cnt: got %h expected %h", e.tag, instret_cnt, e.instret);
        end
        checks++;
        if (redirect_cnt !== e.redir) begin
            errors++; $display("FAIL %s redirect_cnt: got %h expected %h", e.tag, redirect_cnt, e.redir);
        end
        checks++;
        if (trace_count !== e.count) begin
            errors++; $display("FAIL %s trace_count: got %0d expected %0d", e.tag, trace_count, e.count);
        end
        checks++;
        if (trace_overflow !== e.ovf) begin
            errors++; $display("FAIL %s trace_overflow: got %b expected %b", e.tag, trace_overflow, e.ovf);
        end
        checks++;
        if (misalign_flag !== e.flag) begin
            errors++; $display("FAIL %s misalign_flag: got %b expected %b", e.tag, misalign_flag, e.flag);
        end
        checks++;
        if (misalign_addr !== e.addr) begin
            errors++; $display("FAIL %s misalign_addr: got %h expected %h", e.tag, misalign_addr, e.addr);
        end
        #4 pc_reg_clk_gated = 1'b0;
        #3;
    endtask

    // Sweep every read index against the history model
    task automatic test_read_sweep(input string tag);
        logic        ev;
        logic [31:0] es, et;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd_idx = IDX_BITS'(i);
            #1;
            ev = (i < hist.size());
            es = ev ? hist[i][63:32] : 32'd0;
            et = ev ? hist[i][31:0]  : 32'd0;
            checks++;
            if (rd_valid !== ev || rd_src_pc !== es || rd_tgt_pc !== et) begin
                errors++;
                $display("FAIL %s read idx %0d: got v=%b src=%h tgt=%h expected v=%b src=%h tgt=%h",
                         tag, i, rd_valid, rd_src_pc, rd_tgt_pc, ev, es, et);
            end
        end
    endtask

    task automatic test_reset();
        do_retire(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, "reset");
        rd_idx = '0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_src_pc !== 32'd0 || rd_tgt_pc !== 32'd0) begin
            errors++; $display("FAIL reset_read: got v=%b src=%h tgt=%h expected v=0 src=0 tgt=0",
                               rd_valid, rd_src_pc, rd_tgt_pc);
        end
    endtask

    task automatic test_sequential();
        do_retire(1'b0, 32'h80000, 32'h80004, 1'b0, 1'b0, "seq0");
        do_retire(1'b0, 32'h80004, 32'h80008, 1'b0, 1'b0, "seq1");
        do_retire(1'b0, 32'h80008, 32'h8000C, 1'b0, 1'b0, "seq2");
        rd_idx = '0;
        #1;
        checks++;
        if (instret_cnt !== 32'd3 || redirect_cnt !== 32'd0 || trace_count !== 4'd0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL seq_summary: got instret=%0d redir=%0d count=%0d v=%b expected 3 0 0 0",
                               instret_cnt, redirect_cnt, trace_count, rd_valid);
        end
    endtask

    task automatic test_single_redirect();
        do_retire(1'b0, 32'h80010, 32'h80100, 1'b0, 1'b0, "redir1");
        rd_idx = 3'd0;
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_src_pc !== 32'h80010 || rd_tgt_pc !== 32'h80100) begin
            errors++; $display("FAIL redir1_idx0: got v=%b src=%h tgt=%h expected v=1 src=00080010 tgt=00080100",
                               rd_valid, rd_src_pc, rd_tgt_pc);
        end
        rd_idx = 3'd1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_src_pc !== 32'd0 || rd_tgt_pc !== 32'd0) begin
            errors++; $display("FAIL redir1_idx1: got v=%b src=%h tgt=%h expected v=0 src=0 tgt=0",
                               rd_valid, rd_src_pc, rd_tgt_pc);
        end
        test_read_sweep("redir1");
    endtask

    task automatic test_overflow();
        do_retire(1'b0, 32'h80100, 32'h80104, 1'b0, 1'b1, "ovf_clr");
        for (int i = 0; i < 9; i++) begin
            do_retire(1'b0, 32'h1000 + 32'(i) * 32'h100, 32'h2000 + 32'(i) * 32'h100, 1'b0, 1'b0, "ovf_fill");
        end
        checks++;
        if (trace_count !== 4'd8 || trace_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_state: got count=%0d ovf=%b expected count=8 ovf=1",
                               trace_count, trace_overflow);
        end
        rd_idx = 3'd7;
        #1;
        checks++;
        if (rd_src_pc !== 32'h1100 || rd_tgt_pc !== 32'h2100) begin
            errors++; $display("FAIL ovf_oldest: got src=%h tgt=%h expected src=00001100 tgt=00002100",
                               rd_src_pc, rd_tgt_pc);
        end
        rd_idx = 3'd0;
        #1;
        checks++;
        if (rd_src_pc !== 32'h1800 || rd_tgt_pc !== 32'h2800) begin
            errors++; $display("FAIL ovf_newest: got src=%h tgt=%h expected src=00001800 tgt=00002800",
                               rd_src_pc, rd_tgt_pc);
        end
        test_read_sweep("ovf");
        // Back-to-back wrap past the pointer boundary keeps newest-first order
        do_retire(1'b0, 32'h5000, 32'h6000, 1'b0, 1'b0, "ovf_more0");
        do_retire(1'b0, 32'h5100, 32'h6100, 1'b0, 1'b0, "ovf_more1");
        test_read_sweep("ovf_more");
    endtask

    task automatic test_misalign();
        do_retire(1'b0, 32'h80100, 32'h80102, 1'b0, 1'b0, "mis_first");
        do_retire(1'b0, 32'h80202, 32'h80206, 1'b0, 1'b0, "mis_second");
        checks++;
        if (misalign_flag !== 1'b1 || misalign_addr !== 32'h80102) begin
            errors++; $display("FAIL mis_first_wins: got flag=%b addr=%h expected flag=1 addr=00080102",
                               misalign_flag, misalign_addr);
        end
        // Misaligned target on the clear edge itself must not re-arm the flag
        do_retire(1'b0, 32'h80206, 32'h8020A, 1'b0, 1'b1, "mis_clr");
        checks++;
        if (misalign_flag !== 1'b0 || misalign_addr !== 32'd0) begin
            errors++; $display("FAIL mis_clr: got flag=%b addr=%h expected flag=0 addr=0",
                               misalign_flag, misalign_addr);
        end
    endtask

    task automatic test_freeze_clr();
        logic [31:0] prev_redir;
        logic [31:0] prev_inst;
        for (int i = 0; i < 4; i++) begin
            do_retire(1'b0, 32'h4000 + 32'(i) * 32'h10, 32'h7000 + 32'(i) * 32'h20, 1'b0, 1'b0, "fc_fill");
        end
        prev_redir = m_redir;
        do_retire(1'b0, 32'h4100, 32'h9000, 1'b1, 1'b0, "freeze");
        checks++;
        if (trace_count !== 4'd4 || redirect_cnt !== prev_redir + 32'd1) begin
            errors++; $display("FAIL freeze: got count=%0d redir=%0d expected count=4 redir=%0d",
                               trace_count, redirect_cnt, prev_redir + 32'd1);
        end
        test_read_sweep("freeze");
        prev_redir = m_redir;
        prev_inst  = m_instret;
        do_retire(1'b0, 32'h4200, 32'hA000, 1'b0, 1'b1, "clr_redir");
        checks++;
        if (trace_count !== 4'd0 || instret_cnt !== prev_inst + 32'd1 || redirect_cnt !== prev_redir + 32'd1) begin
            errors++; $display("FAIL clr_redir: got count=%0d inst=%0d redir=%0d expected 0 %0d %0d",
                               trace_count, instret_cnt, redirect_cnt, prev_inst + 32'd1, prev_redir + 32'd1);
        end
        test_read_sweep("clr_redir");
    endtask

    task automatic test_mid_reset();
        logic [31:0] p;
        do_retire(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, "mr_pre");
        for (int i = 0; i < 20; i++) begin
            p = 32'h3000 + 32'(i) * 32'h8;
            do_retire(1'b0, p, (i % 4 == 0) ? p + 32'h40 : p + 32'd4, 1'b0, 1'b0, "mr_fill");
        end
        checks++;
        if (trace_count !== 4'd5 || instret_cnt !== 32'd20) begin
            errors++; $display("FAIL mr_fill: got count=%0d inst=%0d expected count=5 inst=20",
                               trace_count, instret_cnt);
        end
        // Reset wins even with clear, freeze and a misaligned redirect present
        do_retire(1'b1, 32'h3100, 32'h3203, 1'b1, 1'b1, "mr_reset");
        checks++;
        if (trace_count !== 4'd0 || instret_cnt !== 32'd0 || redirect_cnt !== 32'd0 ||
            trace_overflow !== 1'b0 || misalign_flag !== 1'b0 || misalign_addr !== 32'd0) begin
            errors++; $display("FAIL mr_reset: got count=%0d inst=%0d redir=%0d ovf=%b flag=%b addr=%h expected all 0",
                               trace_count, instret_cnt, redirect_cnt, trace_overflow, misalign_flag, misalign_addr);
        end
        test_read_sweep("mr_reset");
        do_retire(1'b0, 32'hFFFFFFFC, 32'h0, 1'b0, 1'b0, "wrap_pc");
        checks++;
        if (instret_cnt !== 32'd1 || redirect_cnt !== 32'd0 || trace_count !== 4'd0) begin
            errors++; $display("FAIL wrap_pc: got inst=%0d redir=%0d count=%0d expected 1 0 0",
                               instret_cnt, redirect_cnt, trace_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pc_reg_clk_gated = 1'b0;
        reset        = 1'b1;
        pc           = '0;
        pc_next      = '0;
        trace_freeze = 1'b0;
        trace_clr    = 1'b0;
        rd_idx       = '0;
        m_instret = 0; m_redir = 0; m_ovf = 0; m_flag = 0; m_addr = 0;
        #10;
        test_reset();
        test_sequential();
        test_single_redirect();
        test_overflow();
        test_misalign();
        test_freeze_clr();
        test_mid_reset();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
